// File: rtl/mtc_slc_ptcalc_align_if.sv
// Pipeline-word / pT-calc input bundle and aligned-pair output bundle.
// The master side drives the SLC words; the slave side is the aligner.
interface mtc_slc_ptcalc_align_if #(
  parameter int PL_WIDTH  = 64,
  parameter int PT_WIDTH  = 48,
  parameter int OCC_WIDTH = 4,
  parameter int CNT_WIDTH = 16
);
  logic [PL_WIDTH-1:0]  i_pl_data;
  logic                 i_pl_valid;
  logic [PT_WIDTH-1:0]  i_pt_data;
  logic                 i_pt_valid;
  logic [PL_WIDTH-1:0]  o_pl_data;
  logic [PT_WIDTH-1:0]  o_pt_data;
  logic                 o_valid;
  logic                 o_timeout;
  logic [OCC_WIDTH-1:0] o_occupancy;
  logic [CNT_WIDTH-1:0] o_overflow_cnt;
  logic [CNT_WIDTH-1:0] o_orphan_cnt;

  modport master (
    output i_pl_data, i_pl_valid,
    output i_pt_data, i_pt_valid,
    input  o_pl_data, o_pt_data,
    input  o_valid, o_timeout,
    input  o_occupancy,
    input  o_overflow_cnt, o_orphan_cnt
  );

  modport slave (
    input  i_pl_data, i_pl_valid,
    input  i_pt_data, i_pt_valid,
    output o_pl_data, o_pt_data,
    output o_valid, o_timeout,
    output o_occupancy,
    output o_overflow_cnt, o_orphan_cnt
  );
endinterface

// File: rtl/mtc_slc_ptcalc_align.sv
// Aligns SLC pipeline words with pT-calc results by MUID
// ahead of the MTC packet formatter.
module mtc_slc_ptcalc_align #(
  parameter int PL_WIDTH    = 64,
  parameter int PT_WIDTH    = 48,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 64,
  parameter int MUID_WIDTH  = 20,
  parameter int PL_MUID_LSB = 0,
  parameter int PT_MUID_LSB = 0,
  parameter int PL_BUSY_BIT = 63,
  parameter int CNT_WIDTH   = 16
) (
  input  logic clock,
  input  logic rst,
  mtc_slc_ptcalc_align_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [PL_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [AW:0]          count;
  logic                 hold_vld;
  logic [PT_WIDTH-1:0]  hold_data;
  logic [TW-1:0]        timer;
  logic [CNT_WIDTH-1:0] ovf_cnt;
  logic [CNT_WIDTH-1:0] orph_cnt;
  logic [PL_WIDTH-1:0]  pl_q;
  logic [PT_WIDTH-1:0]  pt_q;
  logic                 valid_q;
  logic                 to_q;

  logic [PL_WIDTH-1:0] head;
  logic empty;
  logic full;
  logic head_busy;
  logic muid_eq;
  logic pop_busy;
  logic pop_match;
  logic pop_to;
  logic drop_hold;
  logic pop;
  logic push;
  logic ovf_inc;
  logic orph_inc;

  assign head      = mem[rptr];
  assign empty     = (count == '0);
  assign full      = (count == FULL);
  assign head_busy = head[PL_BUSY_BIT];
  assign muid_eq   = head[PL_MUID_LSB +: MUID_WIDTH]
                  == hold_data[PT_MUID_LSB +: MUID_WIDTH];

  always_comb begin
    pop_busy  = 1'b0;
    pop_match = 1'b0;
    drop_hold = 1'b0;
    pop_to    = 1'b0;
    if (!empty && head_busy)
      pop_busy = 1'b1;
    else if (hold_vld && !empty && muid_eq)
      pop_match = 1'b1;
    else if (hold_vld)
      drop_hold = 1'b1;
    else if (!empty && timer == TMAX)
      pop_to = 1'b1;
  end

  assign pop      = pop_busy | pop_match | pop_to;
  assign push     = bus.i_pl_valid && (!full || pop);
  assign ovf_inc  = bus.i_pl_valid && !push;
  // An unconsumed hold word overwritten by a new one is also an orphan.
  assign orph_inc = drop_hold
                 || (bus.i_pt_valid && hold_vld && !pop_match);

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= bus.i_pl_data;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
      timer     <= '0;
      ovf_cnt   <= '0;
      orph_cnt  <= '0;
      pl_q      <= '0;
      pt_q      <= '0;
      valid_q   <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (empty || pop)
        timer <= '0;
      else if (timer != TMAX)
        timer <= timer + 1'b1;
      if (bus.i_pt_valid) begin
        hold_vld  <= 1'b1;
        hold_data <= bus.i_pt_data;
      end else if (pop_match || drop_hold) begin
        hold_vld <= 1'b0;
      end
      valid_q <= pop;
      if (pop) begin
        pl_q <= head;
        pt_q <= pop_match ? hold_data : '0;
        to_q <= pop_to;
      end
      if (ovf_inc && ovf_cnt != CMAX)
        ovf_cnt <= ovf_cnt + 1'b1;
      if (orph_inc && orph_cnt != CMAX)
        orph_cnt <= orph_cnt + 1'b1;
    end
  end

  assign bus.o_pl_data      = pl_q;
  assign bus.o_pt_data      = pt_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_timeout      = to_q;
  assign bus.o_occupancy    = count;
  assign bus.o_overflow_cnt = ovf_cnt;
  assign bus.o_orphan_cnt   = orph_cnt;
endmodule

// File: tb/tb_mtc_slc_ptcalc_align.sv
// Bench for mtc_slc_ptcalc_align: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_mtc_slc_ptcalc_align;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int CMAX    = 65535;

  typedef logic [63:0] pl_t;
  typedef logic [47:0] pt_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mtc_slc_ptcalc_align_if #(
    .PL_WIDTH(64), .PT_WIDTH(48),
    .OCC_WIDTH(4), .CNT_WIDTH(16)
  ) bus ();

  mtc_slc_ptcalc_align #(
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus)
  );

  always #5 clock = ~clock;

  pl_t mq[$];
  logic m_hv;
  pt_t  m_hd;
  int   m_timer, m_ovf, m_orph;
  logic m_valid, m_to;
  pl_t  m_pl;
  pt_t  m_pt;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic pl_t make_pl(input logic [19:0] id,
                                  input logic busy);
    pl_t w;
    w = {$urandom, $urandom};
    w[63] = busy;
    w[19:0] = id;
    return w;
  endfunction

  function automatic pt_t make_pt(input logic [19:0] id);
    pt_t w;
    w = {$urandom, $urandom};
    w[19:0] = id;
    return w;
  endfunction

  task automatic drive(input logic pv, input pl_t pd,
                       input logic tv, input pt_t td);
    bus.i_pl_valid = pv;
    bus.i_pl_data  = pd;
    bus.i_pt_valid = tv;
    bus.i_pt_data  = td;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  // Advance model one cycle from current inputs, then clock the DUT.
  task automatic step();
    logic pop, match, to, dropped, was_empty;
    pl_t h;
    pop = 0; match = 0; to = 0; dropped = 0;
    h = '0;
    if (rst) begin
      mq.delete();
      m_hv = 0; m_hd = '0; m_timer = 0;
      m_ovf = 0; m_orph = 0;
      m_valid = 0; m_to = 0; m_pl = '0; m_pt = '0;
    end else begin
      was_empty = (mq.size() == 0);
      if (!was_empty) h = mq[0];
      if (!was_empty && h[63]) pop = 1;
      else if (m_hv && !was_empty && h[19:0] == m_hd[19:0]) begin
        pop = 1; match = 1;
      end else if (m_hv) begin
        dropped = 1; m_orph = sat(m_orph + 1);
      end else if (!was_empty && m_timer == TIMEOUT - 1) begin
        pop = 1; to = 1;
      end
      if (was_empty || pop) m_timer = 0;
      else if (m_timer < TIMEOUT - 1) m_timer++;
      m_valid = pop;
      if (pop) begin
        m_pl = h;
        m_pt = match ? m_hd : '0;
        m_to = to;
        void'(mq.pop_front());
      end
      if (bus.i_pl_valid) begin
        if (mq.size() < DEPTH) mq.push_back(bus.i_pl_data);
        else m_ovf = sat(m_ovf + 1);
      end
      if (bus.i_pt_valid) begin
        if (m_hv && !match && !dropped) m_orph = sat(m_orph + 1);
        m_hv = 1; m_hd = bus.i_pt_data;
      end else if (match || dropped) begin
        m_hv = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++;
    if ({bus.o_valid, bus.o_timeout} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags got=%b want=00",
               {bus.o_valid, bus.o_timeout});
    end
    tests++;
    if ({bus.o_occupancy, bus.o_overflow_cnt, bus.o_orphan_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_counts occ=%0d ovf=%0d orph=%0d want=0",
               bus.o_occupancy, bus.o_overflow_cnt, bus.o_orphan_cnt);
    end
    tests++;
    if ({bus.o_pl_data, bus.o_pt_data} !== '0) begin
      fails++;
      $display("FAIL reset_data pl=%h pt=%h want=0",
               bus.o_pl_data, bus.o_pt_data);
    end
  endtask

  task automatic test_single_match();
    pl_t p;
    pt_t t;
    do_reset();
    p = make_pl(20'h00123, 1'b0);
    t = make_pt(20'h00123);
    drive(1'b1, p, 1'b0, '0); step();
    idle(); step();
    drive(1'b0, '0, 1'b1, t); step();
    tests++;
    if (bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL match_early got=%b want=0", bus.o_valid);
    end
    idle(); step();
    tests++;
    if ({bus.o_valid, bus.o_timeout} !== 2'b10) begin
      fails++;
      $display("FAIL match_strobe got=%b want=10",
               {bus.o_valid, bus.o_timeout});
    end
    tests++;
    if (bus.o_pl_data !== p || bus.o_pt_data !== t) begin
      fails++;
      $display("FAIL match_data pl=%h/%h pt=%h/%h",
               bus.o_pl_data, p, bus.o_pt_data, t);
    end
    tests++;
    if ({bus.o_overflow_cnt, bus.o_orphan_cnt} !== '0) begin
      fails++;
      $display("FAIL match_counts ovf=%0d orph=%0d want=0",
               bus.o_overflow_cnt, bus.o_orphan_cnt);
    end
    step();
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_occupancy !== 4'd0) begin
      fails++;
      $display("FAIL match_after valid=%b occ=%0d want=0/0",
               bus.o_valid, bus.o_occupancy);
    end
  endtask

  task automatic test_busy();
    pl_t p;
    do_reset();
    p = make_pl(20'h00777, 1'b1);
    drive(1'b1, p, 1'b0, '0); step();
    idle();
    tests++;
    if (bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL busy_early got=%b want=0", bus.o_valid);
    end
    step();
    tests++;
    if (bus.o_valid !== 1'b1 || bus.o_timeout !== 1'b0
        || bus.o_pt_data !== '0 || bus.o_pl_data !== p) begin
      fails++;
      $display("FAIL busy_out v=%b to=%b pt=%h pl=%h want pl=%h",
               bus.o_valid, bus.o_timeout, bus.o_pt_data,
               bus.o_pl_data, p);
    end
  endtask

  task automatic test_timeout();
    pl_t p;
    int n;
    do_reset();
    p = make_pl(20'h00055, 1'b0);
    drive(1'b1, p, 1'b0, '0); step();
    idle();
    n = 1;
    while (!bus.o_valid && n < 200) begin
      step();
      n++;
    end
    tests++;
    if (n != TIMEOUT + 1) begin
      fails++;
      $display("FAIL timeout_cycle got=%0d want=%0d", n, TIMEOUT + 1);
    end
    tests++;
    if (bus.o_timeout !== 1'b1 || bus.o_pt_data !== '0
        || bus.o_pl_data !== p) begin
      fails++;
      $display("FAIL timeout_out to=%b pt=%h pl=%h want 1/0/%h",
               bus.o_timeout, bus.o_pt_data, bus.o_pl_data, p);
    end
    drive(1'b0, '0, 1'b1, make_pt(20'h00055)); step();
    idle(); step();
    tests++;
    if (bus.o_orphan_cnt !== 16'd1) begin
      fails++;
      $display("FAIL timeout_late_pt orph=%0d want=1", bus.o_orphan_cnt);
    end
  endtask

  task automatic test_orphan();
    int n;
    do_reset();
    drive(1'b1, make_pl(20'h00010, 1'b0), 1'b0, '0); step();
    drive(1'b0, '0, 1'b1, make_pt(20'h00011)); step();
    idle(); step();
    tests++;
    if (bus.o_orphan_cnt !== 16'd1 || bus.o_occupancy !== 4'd1
        || bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL orphan_mismatch orph=%0d occ=%0d v=%b want 1/1/0",
               bus.o_orphan_cnt, bus.o_occupancy, bus.o_valid);
    end
    n = 0;
    while (!bus.o_valid && n < 200) begin
      step();
      n++;
    end
    tests++;
    if (bus.o_valid !== 1'b1 || bus.o_timeout !== 1'b1) begin
      fails++;
      $display("FAIL orphan_release v=%b to=%b want 1/1",
               bus.o_valid, bus.o_timeout);
    end
    drive(1'b0, '0, 1'b1, make_pt(20'h00011)); step();
    idle(); step();
    tests++;
    if (bus.o_orphan_cnt !== 16'd2 || bus.o_occupancy !== 4'd0) begin
      fails++;
      $display("FAIL orphan_empty orph=%0d occ=%0d want 2/0",
               bus.o_orphan_cnt, bus.o_occupancy);
    end
  endtask

  task automatic test_overflow_wrap();
    pl_t pw[9];
    pt_t tw[8];
    int got;
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 9; i++) begin
        pw[i] = make_pl(20'(32'h100 + rep * 16 + i), 1'b0);
        drive(1'b1, pw[i], 1'b0, '0); step();
      end
      idle();
      tests++;
      if (bus.o_occupancy !== 4'd8
          || bus.o_overflow_cnt !== 16'(rep + 1)) begin
        fails++;
        $display("FAIL ovf_fill rep=%0d occ=%0d ovf=%0d want 8/%0d",
                 rep, bus.o_occupancy, bus.o_overflow_cnt, rep + 1);
      end
      got = 0;
      for (int i = 0; i < 12; i++) begin
        if (i < 8) begin
          tw[i] = make_pt(pw[i][19:0]);
          drive(1'b0, '0, 1'b1, tw[i]);
        end else begin
          idle();
        end
        step();
        if (bus.o_valid) begin
          tests++;
          if (got >= 8 || bus.o_pl_data !== pw[got]
              || bus.o_pt_data !== tw[got] || bus.o_timeout) begin
            fails++;
            $display("FAIL ovf_order rep=%0d idx=%0d pl=%h pt=%h",
                     rep, got, bus.o_pl_data, bus.o_pt_data);
          end
          got++;
        end
      end
      tests++;
      if (got != 8 || bus.o_occupancy !== 4'd0
          || bus.o_orphan_cnt !== 16'd0) begin
        fails++;
        $display("FAIL ovf_drain rep=%0d pairs=%0d occ=%0d orph=%0d",
                 rep, got, bus.o_occupancy, bus.o_orphan_cnt);
      end
    end
  endtask

  task automatic test_full_push_pop();
    pl_t pw[8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pw[i] = make_pl(20'(32'h200 + i), 1'b0);
      drive(1'b1, pw[i], 1'b0, '0); step();
    end
    drive(1'b0, '0, 1'b1, make_pt(pw[0][19:0])); step();
    drive(1'b1, make_pl(20'h00208, 1'b0), 1'b0, '0); step();
    idle();
    tests++;
    if (bus.o_occupancy !== 4'd8 || bus.o_overflow_cnt !== 16'd0
        || bus.o_valid !== 1'b1 || bus.o_pl_data !== pw[0]) begin
      fails++;
      $display("FAIL full_push_pop occ=%0d ovf=%0d v=%b pl=%h",
               bus.o_occupancy, bus.o_overflow_cnt, bus.o_valid,
               bus.o_pl_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, make_pl(20'(32'h300 + i), 1'b0), 1'b0, '0); step();
    end
    drive(1'b0, '0, 1'b1, make_pt(20'h003FF)); step();
    idle(); step();
    tests++;
    if (bus.o_occupancy !== 4'd4 || bus.o_orphan_cnt !== 16'd1) begin
      fails++;
      $display("FAIL midrst_pre occ=%0d orph=%0d want 4/1",
               bus.o_occupancy, bus.o_orphan_cnt);
    end
    rst = 1'b1;
    drive(1'b1, make_pl(20'h00300, 1'b1), 1'b1, make_pt(20'h00300));
    step();
    rst = 1'b0;
    idle();
    tests++;
    if (bus.o_occupancy !== 4'd0 || bus.o_valid !== 1'b0
        || bus.o_orphan_cnt !== 16'd0
        || bus.o_overflow_cnt !== 16'd0) begin
      fails++;
      $display("FAIL midrst occ=%0d v=%b orph=%0d ovf=%0d want 0",
               bus.o_occupancy, bus.o_valid, bus.o_orphan_cnt,
               bus.o_overflow_cnt);
    end
    step();
    step();
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_occupancy !== 4'd0) begin
      fails++;
      $display("FAIL midrst_leak v=%b occ=%0d want 0/0",
               bus.o_valid, bus.o_occupancy);
    end
  endtask

  task automatic test_random();
    logic pv, tv;
    logic [19:0] id;
    pl_t p;
    pt_t t;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      pv = ($urandom_range(0, 9) < 4);
      tv = ($urandom_range(0, 9) < 4);
      p = make_pl(20'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0));
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        id = mq[0][19:0];
      else
        id = 20'($urandom_range(0, 3));
      t = make_pt(id);
      drive(pv, p, tv, t);
      step();
      tests++;
      if (bus.o_valid !== m_valid || bus.o_timeout !== m_to
          || bus.o_pl_data !== m_pl || bus.o_pt_data !== m_pt) begin
        fails++;
        $display("FAIL rand_out c=%0d v=%b/%b to=%b/%b pl=%h/%h pt=%h/%h",
                 c, bus.o_valid, m_valid, bus.o_timeout, m_to,
                 bus.o_pl_data, m_pl, bus.o_pt_data, m_pt);
      end
      tests++;
      if (bus.o_occupancy !== 4'(mq.size())
          || bus.o_overflow_cnt !== 16'(m_ovf)
          || bus.o_orphan_cnt !== 16'(m_orph)) begin
        fails++;
        $display("FAIL rand_cnt c=%0d occ=%0d/%0d ovf=%0d/%0d orph=%0d/%0d",
                 c, bus.o_occupancy, mq.size(), bus.o_overflow_cnt,
                 m_ovf, bus.o_orphan_cnt, m_orph);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    idle();
    test_reset();
    test_single_match();
    test_busy();
    test_timeout();
    test_orphan();
    test_overflow_wrap();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mtc_slc_ptcalc_align.md
Name: mtc_slc_ptcalc_align

Overview:
- Upstream neighbour of the MTC packet formatter inside the MTC builder.
- Buffers SLC pipeline words (PL2MTC) in arrival order and pairs each one with its pT-calculator result (PTCALC2MTC), matching on muon ID (MUID).
- Delivers each aligned pair to the formatter as a single registered valid strobe.
- Busy entries and timed-out entries are released with a zero pT-calc word; stray pT-calc words are dropped and counted.

Parameters:
- PL_WIDTH, PL2MTC_LEN, width of SLC pipeline word
- PT_WIDTH, PTCALC2MTC_LEN, width of pT-calc word
- DEPTH, 8, pipeline-word FIFO entries (power of two, >=2)
- TIMEOUT, 64, cycles an entry may sit at FIFO head before forced release (>=2)
- MUID_WIDTH, 20, MUID field width
- PL_MUID_LSB, PL2MTC_SLC_MUID_LSB, MUID position in pipeline word
- PT_MUID_LSB, PTCALC2MTC_SLC_MUID_LSB, MUID position in pT-calc word
- PL_BUSY_BIT, PL2MTC_BUSY_LSB, busy flag position in pipeline word
- CNT_WIDTH, 16, error counter width

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_pl_data  in  PL_WIDTH  SLC pipeline word
- i_pl_valid  in  1  pipeline word strobe
- i_pt_data  in  PT_WIDTH  pT-calc result
- i_pt_valid  in  1  pT-calc strobe
- o_pl_data  out  PL_WIDTH  aligned pipeline word to formatter
- o_pt_data  out  PT_WIDTH  aligned pT-calc word; zero when busy or timed out
- o_valid  out  1  aligned pair strobe, one cycle
- o_timeout  out  1  qualifies o_valid: pair released by timeout
- o_occupancy  out  $clog2(DEPTH)+1  FIFO fill count
- o_overflow_cnt  out  CNT_WIDTH  pipeline words dropped because FIFO full
- o_orphan_cnt  out  CNT_WIDTH  pT-calc words dropped as unmatched

Behaviour:
- Reset: all outputs 0, FIFO empty, hold register empty, head timer 0, counters 0. Reset applies at any cycle; in-flight data is discarded with no output.
- Push:
  - i_pl_valid at cycle N writes the FIFO tail; the entry is visible at head from N+1.
  - A push is accepted if occupancy<DEPTH, or if occupancy==DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped and o_overflow_cnt increments.
- pT hold register:
  - i_pt_valid at N loads a 1-deep hold register at N+1.
  - If the hold register is still valid and not consumed in that cycle, the old word is dropped and o_orphan_cnt increments.
- Head arbitration: evaluated each cycle, at most one pop, priority in this order:
  1. Head busy bit=1 -> pop; o_pt_data=0, o_timeout=0.
  2. Hold valid and hold MUID == head MUID -> pop with the hold word; clear hold.
  3. Hold valid and (MUID mismatch or FIFO empty) -> clear hold, o_orphan_cnt++; no pop.
  4. Head timer == TIMEOUT-1 -> pop; o_pt_data=0, o_timeout=1.
- Output registering: a pop at cycle M gives o_valid=1 at M+1 with registered data. o_valid is 0 otherwise; data holds its last value.
- Latency:
  - pl at N, pt at N+1 -> output at N+3 minimum.
  - pl at N with busy=1 -> output at N+2.
- Head timer: resets to 0 on every pop and while the FIFO is empty. Otherwise it increments by one per cycle while a non-busy head waits.
- Timeout vs. match: a match in the same cycle as timer expiry wins (priority 2 over 4).
- Counters saturate at all-ones and never wrap.
- FIFO pointers wrap modulo DEPTH.
- o_occupancy reflects the registered count after that cycle's push/pop.

Test Plan:
- Single match: pl MUID=0x00123 at cycle 10, pt MUID=0x00123 at cycle 12 -> o_valid at cycle 14 with both words, o_timeout=0, counters 0.
- Busy bypass: pl with busy=1 at cycle 5, no pt -> o_valid at cycle 7, o_pt_data=0, o_timeout=0.
- Timeout: non-busy pl at cycle 0, no pt -> o_valid=1, o_timeout=1, o_pt_data=0 at cycle 1+TIMEOUT (cycle 65). A matching pt arriving afterwards -> o_orphan_cnt=1.
- Orphan/mismatch: head MUID=0x10, pt MUID=0x11 -> hold dropped, o_orphan_cnt=1, head still waiting. pt with FIFO empty -> o_orphan_cnt=2.
- Overflow and wrap:
  - 9 back-to-back non-busy pl words with DEPTH=8 and no pt -> o_occupancy=8, o_overflow_cnt=1.
  - Then 8 matching pt words in order -> 8 pairs in FIFO order, o_occupancy=0.
  - Repeat 3 times to exercise pointer wrap.
- Simultaneous push+pop at full and mid-operation reset:
  - With occupancy=8, a pop and a push in the same cycle -> push accepted, occupancy stays 8.
  - rst asserted with 4 entries queued -> next cycle occupancy=0, o_valid=0, counters 0.
